// File: rtl/bp_be_fp_retire.sv
// rtl/bp_be_fp_retire.sv - FP pipe tag tracking, NaN-boxed writeback, sticky fflags and RAW hazard detect.
// Forwarding outputs are added when BP_FP_RETIRE_BYPASS_EN is defined.
module bp_be_fp_retire #(
  parameter int latency_p        = 4,
  parameter int data_width_p     = 64,
  parameter int reg_addr_width_p = 5
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  input  logic [reg_addr_width_p-1:0]   rd_addr_i,
  input  logic                          opr_i,
  input  logic                          rf_w_i,
  input  logic [latency_p-1:0]          kill_i,
  input  logic [data_width_p-1:0]       data_i,
  input  logic [4:0]                    fflags_i,
  output logic                          wb_v_o,
  output logic [reg_addr_width_p-1:0]   wb_rd_addr_o,
  output logic [data_width_p-1:0]       wb_data_o,
  input  logic                          csr_w_v_i,
  input  logic [4:0]                    csr_data_i,
  output logic [4:0]                    fflags_o,
  input  logic [3*reg_addr_width_p-1:0] rs_addr_i,
  output logic                          hazard_o,
  output logic                          busy_o
`ifdef BP_FP_RETIRE_BYPASS_EN
  ,output logic                         bypass_v_o
  ,output logic [data_width_p-1:0]      bypass_data_o
`endif
);

  localparam int last_lp = latency_p - 1;

  logic [latency_p-1:0]        v_q, v_d;
  logic [latency_p-1:0]        opr_q, rf_w_q;
  logic [reg_addr_width_p-1:0] rd_q [latency_p];
  logic [4:0]                  fflags_q, fflags_d;
  logic                        ret;
  logic                        fwd_last;

  // A kill drops only the valid bit; the tag fields ride along unqualified.
  assign v_d = {v_q[latency_p-2:0] & ~kill_i[latency_p-2:0], v_i};
  assign ret = v_q[last_lp] & ~kill_i[last_lp];

  always_comb begin
    fflags_d = fflags_q;
    if (csr_w_v_i)
      fflags_d = csr_data_i;
    else if (ret)
      fflags_d = fflags_q | fflags_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q      <= '0;
      fflags_q <= '0;
    end else begin
      v_q      <= v_d;
      fflags_q <= fflags_d;
    end
  end

  always_ff @(posedge clk_i) begin
    opr_q   <= {opr_q[latency_p-2:0], opr_i};
    rf_w_q  <= {rf_w_q[latency_p-2:0], rf_w_i};
    rd_q[0] <= rd_addr_i;
    for (int k = 1; k < latency_p; k++)
      rd_q[k] <= rd_q[k-1];
  end

  assign wb_v_o       = ret & rf_w_q[last_lp];
  assign wb_rd_addr_o = rd_q[last_lp];
  assign wb_data_o    = opr_q[last_lp] ? data_i
                                       : {{(data_width_p-32){1'b1}}, data_i[31:0]};
  assign fflags_o     = fflags_q;
  assign busy_o       = |v_q;

`ifdef BP_FP_RETIRE_BYPASS_EN
  assign bypass_v_o    = wb_v_o;
  assign bypass_data_o = wb_data_o;
  assign fwd_last      = wb_v_o;
`else
  assign fwd_last      = 1'b0;
`endif

  function automatic logic rs_match(input logic [reg_addr_width_p-1:0]   a,
                                    input logic [3*reg_addr_width_p-1:0] rs);
    rs_match = 1'b0;
    for (int r = 0; r < 3; r++)
      if (rs[r*reg_addr_width_p +: reg_addr_width_p] == a)
        rs_match = 1'b1;
  endfunction

  // Conservative: stages being killed this cycle still report a hazard.
  always_comb begin
    hazard_o = v_i & rf_w_i & rs_match(rd_addr_i, rs_addr_i);
    for (int j = 0; j < latency_p; j++)
      if (v_q[j] & rf_w_q[j] & rs_match(rd_q[j], rs_addr_i) & ~((j == last_lp) & fwd_last))
        hazard_o = 1'b1;
  end

endmodule
